// File: rtl/jtkcpu_stack_if.sv
// Memory bus between the JTKCPU stack engine (master) and the memory system (slave).
interface jtkcpu_stack_if;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        we;
  logic        rd;
  logic        mem_busy;
  logic [7:0]  din;

  modport master (output addr, dout, we, rd, input mem_busy, din);
  modport slave  (input addr, dout, we, rd, output mem_busy, din);
endinterface

// File: rtl/jtkcpu_stack.sv
// JTKCPU stack push/pull engine: moves a register list byte by byte through the U or S stack.
// Optional macro JTKCPU_STKWRAP_EN builds the pointer wrap-around flag (stk_wrap).
module jtkcpu_stack (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        psh_go,
  input  logic        pul_go,
  input  logic        psh_all,
  input  logic        psh_cc,
  input  logic        psh_pc,
  input  logic        rti_cc,
  input  logic        rti_other,
  input  logic        use_u,
  input  logic [7:0]  postbyte,
  input  logic [7:0]  cc,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  dp,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] u,
  input  logic [15:0] s,
  input  logic [15:0] pc,
  jtkcpu_stack_if.master bus,
  output logic        stack_busy,
  output logic [15:0] pul_data,
  output logic        ld_cc,
  output logic        ld_a,
  output logic        ld_b,
  output logic        ld_dp,
  output logic        ld_x,
  output logic        ld_y,
  output logic        ld_us,
  output logic        ld_pc,
  output logic [15:0] sp_out,
  output logic        sp_we,
  output logic        stk_wrap
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SCAN    = 3'd1;
  localparam logic [2:0] XFER_LO = 3'd2;
  localparam logic [2:0] XFER_HI = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]  state_reg;
  logic [7:0]  mask_reg;
  logic [15:0] ptr_reg;
  logic [15:0] other_reg;
  logic [2:0]  sel_reg;
  logic        push_reg;
  logic [7:0]  hi_reg;
  logic [15:0] pul_data_reg;
  logic [7:0]  ld_reg;
  logic [15:0] sp_out_reg;

  logic        go;
  logic [7:0]  go_mask;
  logic [2:0]  idx;
  logic        wide;
  logic [15:0] word;
  logic        xfer;
  logic        dec_now;
  logic        inc_now;

  assign go = psh_go | pul_go;

  always_comb begin
    go_mask = postbyte;
    if (psh_go) begin
      if (psh_all)     go_mask = 8'hFF;
      else if (psh_pc) go_mask = 8'h80;
      else if (psh_cc) go_mask = 8'h01;
    end else begin
      if (rti_cc)         go_mask = 8'h01;
      else if (rti_other) go_mask = cc[7] ? 8'hFE : 8'h80;
    end
  end

  // Push walks from PC (bit7) down to CC; pull walks the other way.
  always_comb begin
    idx = 3'd0;
    if (push_reg) begin
      for (int i = 0; i < 8; i++)
        if (mask_reg[i]) idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (mask_reg[i]) idx = 3'(i);
    end
  end

  assign wide = sel_reg[2];

  always_comb begin
    case (sel_reg)
      3'd7:    word = pc;
      3'd6:    word = other_reg;
      3'd5:    word = y;
      3'd4:    word = x;
      3'd3:    word = {8'h00, dp};
      3'd2:    word = {8'h00, b};
      3'd1:    word = {8'h00, a};
      default: word = {8'h00, cc};
    endcase
  end

  assign xfer    = (state_reg == XFER_LO) || (state_reg == XFER_HI);
  assign dec_now = cen && push_reg &&
                   (((state_reg == SCAN) && (mask_reg != 8'h00)) ||
                    ((state_reg == XFER_LO) && wide && !bus.mem_busy));
  assign inc_now = cen && !push_reg && xfer && !bus.mem_busy;

  assign bus.addr = xfer ? ptr_reg : 16'h0000;
  assign bus.we   = xfer && push_reg;
  assign bus.rd   = xfer && !push_reg;
  assign bus.dout = !(xfer && push_reg) ? 8'h00 :
                    (state_reg == XFER_HI) ? word[15:8] : word[7:0];

  assign stack_busy = go || (state_reg != IDLE);
  assign sp_we      = (state_reg == DONE);
  assign sp_out     = sp_out_reg;
  assign pul_data   = pul_data_reg;
  assign {ld_pc, ld_us, ld_y, ld_x, ld_dp, ld_b, ld_a, ld_cc} = ld_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      mask_reg     <= 8'h00;
      ptr_reg      <= 16'h0000;
      other_reg    <= 16'h0000;
      sel_reg      <= 3'd0;
      push_reg     <= 1'b0;
      hi_reg       <= 8'h00;
      pul_data_reg <= 16'h0000;
      ld_reg       <= 8'h00;
      sp_out_reg   <= 16'h0000;
    end else if (cen) begin
      ld_reg <= 8'h00;
      case (state_reg)
        IDLE: begin
          if (go) begin
            mask_reg  <= go_mask;
            ptr_reg   <= use_u ? u : s;
            other_reg <= use_u ? s : u;
            push_reg  <= psh_go;
            if (go_mask == 8'h00) begin
              sp_out_reg <= use_u ? u : s;
              state_reg  <= DONE;
            end else begin
              state_reg <= SCAN;
            end
          end
        end
        SCAN: begin
          if (mask_reg == 8'h00) begin
            sp_out_reg <= ptr_reg;
            state_reg  <= DONE;
          end else begin
            mask_reg[idx] <= 1'b0;
            sel_reg       <= idx;
            // Push always starts with the low byte; pull starts with the high byte of 16-bit regs.
            state_reg     <= (!push_reg && idx[2]) ? XFER_HI : XFER_LO;
          end
        end
        XFER_LO: begin
          if (!bus.mem_busy) begin
            if (push_reg) begin
              state_reg <= wide ? XFER_HI : SCAN;
            end else begin
              pul_data_reg    <= wide ? {hi_reg, bus.din} : {8'h00, bus.din};
              ld_reg[sel_reg] <= 1'b1;
              state_reg       <= SCAN;
            end
          end
        end
        XFER_HI: begin
          if (!bus.mem_busy) begin
            if (push_reg) begin
              state_reg <= SCAN;
            end else begin
              hi_reg    <= bus.din;
              state_reg <= XFER_LO;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
      if (dec_now) ptr_reg <= ptr_reg - 16'd1;
      if (inc_now) ptr_reg <= ptr_reg + 16'd1;
    end
  end

`ifdef JTKCPU_STKWRAP_EN
  logic wrap_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_reg <= 1'b0;
    end else if (cen) begin
      if ((state_reg == IDLE) && go)
        wrap_reg <= 1'b0;
      else if ((dec_now && ptr_reg == 16'h0000) || (inc_now && ptr_reg == 16'hFFFF))
        wrap_reg <= 1'b1;
    end
  end

  assign stk_wrap = wrap_reg;
`else
  assign stk_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_jtkcpu_stack.sv
// Scoreboard bench for jtkcpu_stack: expected bus writes/reads, loads and final pointers are queued and popped as the DUT produces them.
module tb_jtkcpu_stack;
  logic        clk = 1'b0;
  logic        rst, cen;
  logic        psh_go, pul_go, psh_all, psh_cc, psh_pc, rti_cc, rti_other, use_u;
  logic [7:0]  postbyte, cc, a, b, dp;
  logic [15:0] x, y, u, s, pc;
  logic        stack_busy;
  logic [15:0] pul_data, sp_out;
  logic        ld_cc, ld_a, ld_b, ld_dp, ld_x, ld_y, ld_us, ld_pc;
  logic        sp_we, stk_wrap;

  jtkcpu_stack_if bus ();

  jtkcpu_stack dut (
    .clk(clk), .rst(rst), .cen(cen),
    .psh_go(psh_go), .pul_go(pul_go), .psh_all(psh_all), .psh_cc(psh_cc), .psh_pc(psh_pc),
    .rti_cc(rti_cc), .rti_other(rti_other), .use_u(use_u), .postbyte(postbyte),
    .cc(cc), .a(a), .b(b), .dp(dp), .x(x), .y(y), .u(u), .s(s), .pc(pc),
    .bus(bus.master),
    .stack_busy(stack_busy), .pul_data(pul_data),
    .ld_cc(ld_cc), .ld_a(ld_a), .ld_b(ld_b), .ld_dp(ld_dp),
    .ld_x(ld_x), .ld_y(ld_y), .ld_us(ld_us), .ld_pc(ld_pc),
    .sp_out(sp_out), .sp_we(sp_we), .stk_wrap(stk_wrap)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  logic       busy_force, stall_en;
  logic [1:0] stall_cnt;
  logic [7:0] ld_vec;

  assign ld_vec       = {ld_pc, ld_us, ld_y, ld_x, ld_dp, ld_b, ld_a, ld_cc};
  assign bus.mem_busy = busy_force | (stall_en && stall_cnt != 2'd3);
  assign bus.din      = mem[bus.addr];

  always @(posedge clk) begin
    if (cen && bus.we && !bus.mem_busy) mem[bus.addr] <= bus.dout;
    if (!stall_en) stall_cnt <= 2'd0;
    else if (cen && (bus.rd || bus.we)) stall_cnt <= stall_cnt + 2'd1;
  end

  int compared = 0;
  int mismatched = 0;

  logic [31:0] exp_wr [$];
  logic [31:0] exp_rd [$];
  logic [31:0] exp_ld [$];
  logic [31:0] exp_sp [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic unexpected(input string tag, input logic [31:0] obs);
    compared++;
    mismatched++;
    $error("FAIL %s: observed %h expected none", tag, obs);
  endtask

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && cen) begin
      if (bus.we && !bus.mem_busy) begin
        if (exp_wr.size() == 0) unexpected("write", {8'h00, bus.addr, bus.dout});
        else begin
          e = exp_wr.pop_front();
          $display("write addr=%h data=%h", bus.addr, bus.dout);
          check("write", {8'h00, bus.addr, bus.dout}, e);
        end
      end
      if (bus.rd) begin
        if (exp_rd.size() == 0) unexpected("read", {16'h0000, bus.addr});
        else if (bus.mem_busy) check("read_hold_addr", {16'h0000, bus.addr}, exp_rd[0]);
        else begin
          e = exp_rd.pop_front();
          $display("read  addr=%h data=%h", bus.addr, bus.din);
          check("read", {16'h0000, bus.addr}, e);
        end
      end
      if (ld_vec != 8'h00) begin
        if (exp_ld.size() == 0) unexpected("load", {8'h00, ld_vec, pul_data});
        else begin
          e = exp_ld.pop_front();
          $display("load  strobes=%b data=%h", ld_vec, pul_data);
          check("load", {8'h00, ld_vec, pul_data}, e);
        end
      end
      if (sp_we) begin
        if (exp_sp.size() == 0) unexpected("sp_out", {16'h0000, sp_out});
        else begin
          e = exp_sp.pop_front();
          $display("done  sp_out=%h", sp_out);
          check("sp_out", {16'h0000, sp_out}, e);
        end
      end
    end
  end

  task automatic run_op(input logic p, input logic q, output int cycles);
    psh_go = p;
    pul_go = q;
    @(posedge clk); #1;
    psh_go = 1'b0;
    pul_go = 1'b0;
    cycles = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!stack_busy) break;
      cycles++;
    end
    check("busy_released", {31'd0, stack_busy}, 32'd0);
  endtask

  task automatic drained(input string tag);
    check({tag, "_wr_left"}, exp_wr.size(), 0);
    check({tag, "_rd_left"}, exp_rd.size(), 0);
    check({tag, "_ld_left"}, exp_ld.size(), 0);
    check({tag, "_sp_left"}, exp_sp.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  {31'd0, stack_busy}, 32'd0);
    check({tag, "_we_rd"}, {30'd0, bus.we, bus.rd}, 32'd0);
    check({tag, "_addr"},  {16'd0, bus.addr}, 32'd0);
    check({tag, "_dout"},  {24'd0, bus.dout}, 32'd0);
    check({tag, "_ld"},    {24'd0, ld_vec}, 32'd0);
    check({tag, "_pul"},   {16'd0, pul_data}, 32'd0);
    check({tag, "_sp"},    {15'd0, sp_out, sp_we}, 32'd0);
    check({tag, "_wrap"},  {31'd0, stk_wrap}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic exp_wrap;
`ifdef JTKCPU_STKWRAP_EN
    exp_wrap = 1'b1;
`else
    exp_wrap = 1'b0;
`endif
    rst = 1'b1; cen = 1'b1; busy_force = 1'b0; stall_en = 1'b0;
    psh_go = 0; pul_go = 0; psh_all = 0; psh_cc = 0; psh_pc = 0;
    rti_cc = 0; rti_other = 0; use_u = 0; postbyte = 8'h00;
    cc = 8'h04; a = 8'h03; b = 8'h02; dp = 8'h01;
    x = 16'h99AA; y = 16'h7788; u = 16'h5566; s = 16'h1000; pc = 16'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Push everything from S=0x1000.
    psh_all = 1'b1;
    exp_wr.push_back(32'h000FFF34); exp_wr.push_back(32'h000FFE12);
    exp_wr.push_back(32'h000FFD66); exp_wr.push_back(32'h000FFC55);
    exp_wr.push_back(32'h000FFB88); exp_wr.push_back(32'h000FFA77);
    exp_wr.push_back(32'h000FF9AA); exp_wr.push_back(32'h000FF899);
    exp_wr.push_back(32'h000FF701); exp_wr.push_back(32'h000FF602);
    exp_wr.push_back(32'h000FF503); exp_wr.push_back(32'h000FF404);
    exp_sp.push_back(32'h00000FF4);
    run_op(1'b1, 1'b0, cyc);
    psh_all = 1'b0;
    drained("push_all");
    check("push_all_wrap", {31'd0, stk_wrap}, 32'd0);

    // Pull CC only.
    rti_cc = 1'b1; s = 16'h0FF4;
    exp_rd.push_back(32'h0FF4);
    exp_ld.push_back(32'h00010004);
    exp_sp.push_back(32'h00000FF5);
    run_op(1'b0, 1'b1, cyc);
    rti_cc = 1'b0;
    drained("rti_cc");

    // RTI with E clear: PC only.
    rti_other = 1'b1; cc = 8'h04; s = 16'h0FFE;
    exp_rd.push_back(32'h0FFE); exp_rd.push_back(32'h0FFF);
    exp_ld.push_back(32'h00801234);
    exp_sp.push_back(32'h00001000);
    run_op(1'b0, 1'b1, cyc);
    drained("rti_pc");

    // RTI with E set: everything but CC, in pull order.
    cc = 8'h84; s = 16'h0FF5;
    for (int i = 16'h0FF5; i <= 16'h0FFF; i++) exp_rd.push_back(32'(i));
    exp_ld.push_back(32'h00020003); exp_ld.push_back(32'h00040002);
    exp_ld.push_back(32'h00080001); exp_ld.push_back(32'h001099AA);
    exp_ld.push_back(32'h00207788); exp_ld.push_back(32'h00405566);
    exp_ld.push_back(32'h00801234);
    exp_sp.push_back(32'h00001000);
    run_op(1'b0, 1'b1, cyc);
    rti_other = 1'b0; cc = 8'h04;
    drained("rti_full");

    // Pull A,B with three wait cycles on every read.
    postbyte = 8'h06; s = 16'h0FF5; stall_en = 1'b1;
    exp_rd.push_back(32'h0FF5); exp_rd.push_back(32'h0FF6);
    exp_ld.push_back(32'h00020003); exp_ld.push_back(32'h00040002);
    exp_sp.push_back(32'h00000FF7);
    run_op(1'b0, 1'b1, cyc);
    stall_en = 1'b0;
    drained("pull_stall");

    // Empty push: go cycle plus DONE only.
    postbyte = 8'h00; s = 16'h3456;
    exp_sp.push_back(32'h00003456);
    run_op(1'b1, 1'b0, cyc);
    check("empty_busy_cycles", 32'(cyc), 32'd2);
    drained("empty");

    // Push CC from S=0x0000: wraps to 0xFFFF.
    postbyte = 8'h01; s = 16'h0000;
    exp_wr.push_back(32'h00FFFF04);
    exp_sp.push_back(32'h0000FFFF);
    run_op(1'b1, 1'b0, cyc);
    drained("wrap");
    check("wrap_flag", {31'd0, stk_wrap}, {31'd0, exp_wrap});

    // Simultaneous push/pull go, then reset in the middle of the push.
    psh_all = 1'b1; s = 16'h2000;
    exp_wr.push_back(32'h001FFF34); exp_wr.push_back(32'h001FFE12);
    exp_wr.push_back(32'h001FFD66);
    psh_go = 1'b1; pul_go = 1'b1;
    @(posedge clk); #1;
    psh_go = 1'b0; pul_go = 1'b0; psh_all = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp_wr.size() == 0) break;
      @(posedge clk); #1;
    end
    check("mid_push_writes_seen", exp_wr.size(), 0);
    rst = 1'b1; busy_force = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; busy_force = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    repeat (10) @(negedge clk);
    check("abort_busy", {31'd0, stack_busy}, 32'd0);
    drained("abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
